// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even parity, STOP_BITS stop bits.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] DATA,
   input  logic                 DATA_VALID,
   output logic                 TXD,
   output logic                 TX_BUSY,
   output logic                 TX_DONE
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     clk_cnt_q;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 txd_q;
   logic                 busy_q;
   logic                 done_q;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   assign TXD     = txd_q;
   assign TX_BUSY = busy_q;
   assign TX_DONE = done_q;

   // TXD is registered but reset asynchronously, so the line goes idle the moment RST rises.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (DATA_VALID && !busy_q) begin
                  shift_q   <= DATA;
                  state_q   <= S_START;
                  busy_q    <= 1'b1;
                  txd_q     <= 1'b0;
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                  parity_q  <= ^DATA;
`endif
               end
            end
            S_START: begin
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= S_DATA;
                  txd_q     <= shift_q[0];
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q <= '0;
                  shift_q   <= shift_q >> 1;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q   <= S_PARITY;
                     txd_q     <= parity_q;
`else
                     state_q   <= S_STOP;
                     txd_q     <= 1'b1;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                     // shift_q[1] becomes bit 0 on this same edge.
                     txd_q     <= shift_q[1];
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= S_STOP;
                  txd_q     <= 1'b1;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
`endif
            S_STOP: begin
               txd_q <= 1'b1;
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q <= '0;
                  if (bit_cnt_q == STOP_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= S_IDLE;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q   <= S_IDLE;
               clk_cnt_q <= '0;
               bit_cnt_q <= '0;
               txd_q     <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (8N1 at 8 clocks/bit; parity frame when UART_TX_PARITY_EN is defined).
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME  = 88;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int FRAME  = 80;
   localparam bit PAR_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] DATA;
   logic       DATA_VALID;
   logic       TXD;
   logic       TX_BUSY;
   logic       TX_DONE;

   int checks = 0;
   int errors = 0;

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA      (DATA),
      .DATA_VALID(DATA_VALID),
      .TXD       (TXD),
      .TX_BUSY   (TX_BUSY),
      .TX_DONE   (TX_DONE)
   );

   always #5 CLK = ~CLK;

   // Expected line level k cycles after the acceptance edge.
   function automatic logic exp_txd(input logic [7:0] b, input int k);
      int slot;
      slot = k / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      if (PAR_EN && slot == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic logic [FRAME-1:0] exp_frame(input logic [7:0] b);
      logic [FRAME-1:0] f;
      for (int k = 0; k < FRAME; k++) f[k] = exp_txd(b, k);
      return f;
   endfunction

   // Sends one byte with a one-cycle DATA_VALID and records the line; DATA is scrambled once accepted.
   task automatic send_capture(input logic [7:0] b, input bit poke,
                               output logic [FRAME-1:0] line, output int busy_cnt,
                               output int done_in, output logic done_end,
                               output logic done_next, output logic busy_after);
      @(negedge CLK);
      DATA = b;
      DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      DATA = ~b;
      busy_cnt = 0;
      done_in = 0;
      for (int k = 0; k < FRAME; k++) begin
         line[k] = TXD;
         if (TX_BUSY) busy_cnt++;
         if (TX_DONE) done_in++;
         DATA_VALID = (poke && k == 40);
         @(negedge CLK);
      end
      done_end = TX_DONE;
      @(negedge CLK);
      done_next = TX_DONE;
      @(negedge CLK);
      busy_after = TX_BUSY;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      DATA = 8'h00;
      DATA_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if ({TXD, TX_BUSY, TX_DONE} !== 3'b100) begin
         errors++;
         $display("FAIL reset_hold: {TXD,BUSY,DONE}=%b expected 100", {TXD, TX_BUSY, TX_DONE});
      end
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         checks++;
         if ({TXD, TX_BUSY, TX_DONE} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle[%0d]: {TXD,BUSY,DONE}=%b expected 100", i, {TXD, TX_BUSY, TX_DONE});
         end
      end
   endtask

   task automatic test_frame_55();
      logic [FRAME-1:0] line;
      int busy_cnt, done_in;
      logic done_end, done_next, busy_after;
      send_capture(8'h55, 1'b1, line, busy_cnt, done_in, done_end, done_next, busy_after);
      checks++;
      if (line !== exp_frame(8'h55)) begin
         errors++;
         $display("FAIL frame55_line: got %h expected %h", line, exp_frame(8'h55));
      end
      checks++;
      if (busy_cnt !== FRAME) begin
         errors++;
         $display("FAIL frame55_busy_len: got %0d expected %0d", busy_cnt, FRAME);
      end
      checks++;
      if (done_in !== 0 || done_end !== 1'b1 || done_next !== 1'b0) begin
         errors++;
         $display("FAIL frame55_done: in_frame=%0d end=%b next=%b expected 0 1 0", done_in, done_end, done_next);
      end
      checks++;
      if (busy_after !== 1'b0) begin
         errors++;
         $display("FAIL frame55_no_queue: busy=%b expected 0", busy_after);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] vals [3];
      logic [FRAME-1:0] line;
      int busy_cnt, done_in;
      logic done_end, done_next, busy_after;
      logic [7:0] rx_data;
      logic rx_error;
      vals[0] = 8'hA5;
      vals[1] = 8'h00;
      vals[2] = 8'hFF;
      for (int v = 0; v < 3; v++) begin
         send_capture(vals[v], 1'b0, line, busy_cnt, done_in, done_end, done_next, busy_after);
         // Receiver view: sample each bit in its middle.
         rx_error = (line[CPB/2] !== 1'b0);
         for (int i = 0; i < 8; i++) rx_data[i] = line[(i + 1) * CPB + CPB/2];
         if (PAR_EN && line[9 * CPB + CPB/2] !== ^rx_data) rx_error = 1'b1;
         if (line[FRAME - CPB/2] !== 1'b1) rx_error = 1'b1;
         checks++;
         if (rx_data !== vals[v] || rx_error !== 1'b0) begin
            errors++;
            $display("FAIL loopback_%h: data=%h err=%b expected %h err=0", vals[v], rx_data, rx_error, vals[v]);
         end
         checks++;
         if (done_end !== 1'b1) begin
            errors++;
            $display("FAIL loopback_%h_done: got %b expected 1", vals[v], done_end);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2*FRAME:0] line;
      logic [2*FRAME:0] expl;
      int dones, run;
      dones = 0;
      @(negedge CLK);
      DATA = 8'h3C;
      DATA_VALID = 1'b1;
      for (int k = 0; k < 2 * FRAME + 6; k++) begin
         @(negedge CLK);
         if (k <= 2 * FRAME) line[k] = TXD;
         if (TX_DONE) dones++;
         if (k == FRAME / 2) DATA = 8'hC3;
         if (k == FRAME + 20) DATA_VALID = 1'b0;
      end
      for (int k = 0; k <= 2 * FRAME; k++) begin
         if (k < FRAME) expl[k] = exp_txd(8'h3C, k);
         else if (k == FRAME) expl[k] = 1'b1;
         else expl[k] = exp_txd(8'hC3, k - FRAME - 1);
      end
      checks++;
      if (line !== expl) begin
         errors++;
         $display("FAIL b2b_line: got %h expected %h", line, expl);
      end
      run = 0;
      for (int j = FRAME; j >= 0; j--) begin
         if (line[j] !== 1'b1) break;
         run++;
      end
      checks++;
      if (run !== CPB + 1) begin
         errors++;
         $display("FAIL b2b_gap: high for %0d cycles expected %0d", run, CPB + 1);
      end
      checks++;
      if (dones !== 2 || TX_BUSY !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done: pulses=%0d busy=%b expected 2 and 0", dones, TX_BUSY);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [FRAME-1:0] line;
      int busy_cnt, done_in, dones;
      logic done_end, done_next, busy_after;
      @(negedge CLK);
      DATA = 8'h0F;
      DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      repeat (30) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      checks++;
      if (TXD !== 1'b1 || TX_BUSY !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: TXD=%b BUSY=%b expected 1 0", TXD, TX_BUSY);
      end
      @(negedge CLK);
      DATA_VALID = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      DATA_VALID = 1'b0;
      dones = 0;
      repeat (FRAME + 5) begin
         @(negedge CLK);
         if (TX_DONE) dones++;
      end
      checks++;
      if (dones !== 0 || TX_BUSY !== 1'b0) begin
         errors++;
         $display("FAIL rst_abandon: done pulses=%0d busy=%b expected 0 0", dones, TX_BUSY);
      end
      send_capture(8'h81, 1'b0, line, busy_cnt, done_in, done_end, done_next, busy_after);
      checks++;
      if (line !== exp_frame(8'h81) || done_end !== 1'b1) begin
         errors++;
         $display("FAIL rst_recover: line=%h done=%b expected %h 1", line, done_end, exp_frame(8'h81));
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [FRAME-1:0] line;
      int busy_cnt, done_in;
      logic done_end, done_next, busy_after;
      send_capture(8'h07, 1'b0, line, busy_cnt, done_in, done_end, done_next, busy_after);
      checks++;
      if (line[9 * CPB + CPB/2] !== 1'b1 || busy_cnt !== 88) begin
         errors++;
         $display("FAIL parity_07: bit=%b busy=%0d expected 1 88", line[9 * CPB + CPB/2], busy_cnt);
      end
      send_capture(8'h03, 1'b0, line, busy_cnt, done_in, done_end, done_next, busy_after);
      checks++;
      if (line[9 * CPB + CPB/2] !== 1'b0 || busy_cnt !== 88) begin
         errors++;
         $display("FAIL parity_03: bit=%b busy=%0d expected 0 88", line[9 * CPB + CPB/2], busy_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_frame_55();
      test_loopback();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
